// File: rtl/xtea_ctr_keystream_if.sv
// Keystream handshake bundle between the XTEA keystream source and its consumer.
interface xtea_ctr_keystream_if #(
  parameter int OUT_BYTES = 1
) ();
  logic                   ks_valid_o;
  logic [8*OUT_BYTES-1:0] ks_data_o;
  logic                   ks_ready_i;

  modport master (output ks_valid_o, output ks_data_o, input ks_ready_i);
  modport slave  (input ks_valid_o, input ks_data_o, output ks_ready_i);
endinterface

// File: rtl/xtea_ctr_keystream.sv
// XTEA counter-mode keystream source: enciphers {nonce, counter} one XTEA cycle per
// clock and serves finished blocks from a prefetch buffer as OUT_BYTES-wide words.
//
// state   | meaning
// S_IDLE  | waiting for enable_i and buffer space
// S_LOAD  | latch nonce, counter and key into the round datapath
// S_ROUND | one XTEA cycle per clock, ROUNDS clocks
// S_PUSH  | write finished block to buffer tail, advance counter
module xtea_ctr_keystream #(
  parameter int ROUNDS    = 32,
  parameter int OUT_BYTES = 1,
  parameter int BUF_DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           nrst,
  input  logic                           restart_i,
  input  logic [31:0]                    nonce_i,
  input  logic [127:0]                   key_i,
  input  logic                           enable_i,
  xtea_ctr_keystream_if.master           ks,
  output logic [$clog2(BUF_DEPTH+1)-1:0] level_o,
  output logic                           busy_o,
  output logic                           ctr_wrap_o
);
  localparam int WORDS = 8 / OUT_BYTES;
  localparam int W     = 8 * OUT_BYTES;
  localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int PW    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int LW    = $clog2(BUF_DEPTH + 1);
  localparam logic [31:0] DELTA = 32'h9E3779B9;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ROUND, S_PUSH} state_t;

  state_t         r_state, w_state_nxt;
  logic [31:0]    r_nonce, r_ctr, w_ctr_nxt;
  logic           r_wrap;
  logic [127:0]   r_key;
  logic [31:0]    r_v0, r_v1, r_sum;
  logic [31:0]    w_v0n, w_v1n, w_sumn, w_k0, w_k1;
  logic [6:0]     r_round;
  logic [63:0]    r_buf [BUF_DEPTH];
  logic [63:0]    w_head;
  logic [PW-1:0]  r_head, r_tail;
  logic [LW-1:0]  r_level;
  logic [IW-1:0]  r_idx;
  logic           w_push, w_xfer, w_last, w_pop;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (enable_i && (r_level < LW'(BUF_DEPTH))) w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = S_ROUND;
      S_ROUND: if (r_round == 7'd0) w_state_nxt = S_PUSH;
      S_PUSH:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (restart_i) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  assign w_push = (r_state == S_PUSH) & ~restart_i;

  always_comb begin
    w_ctr_nxt = r_ctr;
    if (restart_i)   w_ctr_nxt = 32'd0;
    else if (w_push) w_ctr_nxt = r_ctr + 32'd1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_ctr   <= 32'd0;
      r_nonce <= 32'd0;
      r_wrap  <= 1'b0;
    end else begin
      r_ctr <= w_ctr_nxt;
      if (restart_i) begin
        r_nonce <= nonce_i;
        r_wrap  <= 1'b0;
      end else if (w_push && (r_ctr == 32'hFFFF_FFFF)) begin
        r_wrap <= 1'b1;
      end
    end
  end

  assign w_k0   = r_key[32*r_sum[1:0] +: 32];
  assign w_v0n  = r_v0 + ((((r_v1 << 4) ^ (r_v1 >> 5)) + r_v1) ^ (r_sum + w_k0));
  assign w_sumn = r_sum + DELTA;
  assign w_k1   = r_key[32*w_sumn[12:11] +: 32];
  assign w_v1n  = r_v1 + ((((w_v0n << 4) ^ (w_v0n >> 5)) + w_v0n) ^ (w_sumn + w_k1));

  // Round counter runs down; the block is done at terminal count zero.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_v0    <= 32'd0;
      r_v1    <= 32'd0;
      r_sum   <= 32'd0;
      r_key   <= 128'd0;
      r_round <= 7'd0;
    end else begin
      unique case (r_state)
        S_LOAD: begin
          r_v0    <= r_nonce;
          r_v1    <= r_ctr;
          r_sum   <= 32'd0;
          r_key   <= key_i;
          r_round <= 7'(ROUNDS - 1);
        end
        S_ROUND: begin
          r_v0    <= w_v0n;
          r_v1    <= w_v1n;
          r_sum   <= w_sumn;
          r_round <= r_round - 7'd1;
        end
        default: ;
      endcase
    end
  end

  assign w_xfer = ks.ks_valid_o & ks.ks_ready_i;
  assign w_last = (r_idx == IW'(WORDS - 1));
  assign w_pop  = w_xfer & w_last;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < BUF_DEPTH; i++) r_buf[i] <= 64'd0;
      r_head  <= '0;
      r_tail  <= '0;
      r_level <= '0;
      r_idx   <= '0;
    end else if (restart_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_level <= '0;
      r_idx   <= '0;
    end else begin
      if (w_push) begin
        r_buf[r_tail] <= {r_v0, r_v1};
        r_tail        <= f_inc(r_tail);
      end
      if (w_xfer) begin
        if (w_last) begin
          r_idx  <= '0;
          r_head <= f_inc(r_head);
        end else begin
          r_idx <= r_idx + IW'(1);
        end
      end
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign w_head        = r_buf[r_head];
  assign ks.ks_valid_o = (r_level != '0) & ~restart_i;
  assign ks.ks_data_o  = (r_level != '0) ? w_head[W*r_idx +: W] : '0;
  assign level_o       = r_level;
  assign busy_o        = (r_state != S_IDLE);
  assign ctr_wrap_o    = r_wrap;
endmodule

// File: tb/tb_xtea_ctr_keystream.sv
// Bench for xtea_ctr_keystream: byte-wide and 32-bit-wide instances share stimulus;
// expected words are queued from a software XTEA model and popped by per-instance monitors.
module tb_xtea_ctr_keystream;
  localparam logic [31:0]  DELTA = 32'h9E3779B9;
  localparam logic [127:0] K1 = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [127:0] K2 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] K3 = 128'hDEADBEEF_01020304_A5A5A5A5_0F0F0F0F;

  logic         clk = 1'b0, nrst = 1'b0, restart = 1'b0, enable = 1'b0, ready = 1'b0;
  logic [31:0]  nonce = 32'd0;
  logic [127:0] key = 128'd0;
  logic [1:0]   lvl1, lvl4;
  logic         busy1, busy4, wrap1, wrap4;
  int           checks = 0, failures = 0, p1 = 0, p4 = 0, n;
  logic [7:0]   q1[$];
  logic [31:0]  q4[$];

  always #5 clk = ~clk;

  xtea_ctr_keystream_if #(.OUT_BYTES(1)) ks1 ();
  xtea_ctr_keystream_if #(.OUT_BYTES(4)) ks4 ();
  assign ks1.ks_ready_i = ready;
  assign ks4.ks_ready_i = ready;

  xtea_ctr_keystream #(.ROUNDS(32), .OUT_BYTES(1), .BUF_DEPTH(2)) u_d1 (
    .clk(clk), .nrst(nrst), .restart_i(restart), .nonce_i(nonce), .key_i(key),
    .enable_i(enable), .ks(ks1), .level_o(lvl1), .busy_o(busy1), .ctr_wrap_o(wrap1));
  xtea_ctr_keystream #(.ROUNDS(32), .OUT_BYTES(4), .BUF_DEPTH(2)) u_d4 (
    .clk(clk), .nrst(nrst), .restart_i(restart), .nonce_i(nonce), .key_i(key),
    .enable_i(enable), .ks(ks4), .level_o(lvl4), .busy_o(busy4), .ctr_wrap_o(wrap4));

  function automatic logic [63:0] xtea_blk(input logic [31:0] n_in, c_in, input logic [127:0] k);
    logic [31:0] v0, v1, sum;
    logic [31:0] kw [4];
    v0 = n_in; v1 = c_in; sum = 32'd0;
    for (int i = 0; i < 4; i++) kw[i] = k[32*i +: 32];
    for (int r = 0; r < 32; r++) begin
      v0  = v0 + ((((v1 << 4) ^ (v1 >> 5)) + v1) ^ (sum + kw[sum & 32'd3]));
      sum = sum + DELTA;
      v1  = v1 + ((((v0 << 4) ^ (v0 >> 5)) + v0) ^ (sum + kw[(sum >> 11) & 32'd3]));
    end
    return {v0, v1};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic expect_block(input logic [31:0] nv, input logic [31:0] cv, input logic [127:0] kv);
    logic [63:0] blk;
    blk = xtea_blk(nv, cv, kv);
    for (int j = 0; j < 8; j++) q1.push_back(blk[8*j +: 8]);
    for (int w = 0; w < 2; w++) q4.push_back(blk[32*w +: 32]);
  endtask

  always @(negedge clk) begin
    if (nrst && ks1.ks_valid_o && ks1.ks_ready_i) begin
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL d1_unexpected actual=%0h required=none", ks1.ks_data_o);
      end else check("d1_data", 64'(ks1.ks_data_o), 64'(q1.pop_front()));
      p1++;
    end
  end

  always @(negedge clk) begin
    if (nrst && ks4.ks_valid_o && ks4.ks_ready_i) begin
      if (q4.size() == 0) begin
        checks++; failures++;
        $display("FAIL d4_unexpected actual=%0h required=none", ks4.ks_data_o);
      end else check("d4_data", 64'(ks4.ks_data_o), 64'(q4.pop_front()));
      p4++;
    end
  end

  task automatic step(input int cyc);
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that sampled restart.
  task automatic do_restart(input logic [31:0] nv, input logic en, input logic rd);
    nonce = nv; enable = en; ready = rd; restart = 1'b1;
    q1.delete(); q4.delete(); p1 = 0; p4 = 0;
    #1;
    check("restart_valid1", 64'(ks1.ks_valid_o), 64'd0);
    check("restart_valid4", 64'(ks4.ks_valid_o), 64'd0);
    @(posedge clk); #1;
    restart = 1'b0;
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    forever begin
      @(negedge clk);
      if (ks1.ks_valid_o || cnt >= 200) break;
      @(posedge clk);
      cnt++;
    end
  endtask

  task automatic wait_pops(input int t1, input int t4, input int limit, input string name);
    int c = 0;
    while ((p1 < t1 || p4 < t4) && c < limit) begin
      @(posedge clk); #1; c++;
    end
    checks++;
    if (p1 < t1 || p4 < t4) begin
      failures++;
      $display("FAIL %s_timeout actual=%0d/%0d required=%0d/%0d", name, p1, p4, t1, t4);
    end
  endtask

  task automatic wait_level1(input logic [1:0] lv, input int limit, input string name);
    int c = 0;
    while (lvl1 != lv && c < limit) begin
      @(posedge clk); #1; c++;
    end
    check(name, 64'(lvl1), 64'(lv));
  endtask

  initial begin
    repeat (3) @(posedge clk); #1;
    check("rst_valid", 64'(ks1.ks_valid_o), 64'd0);
    check("rst_data1", 64'(ks1.ks_data_o), 64'd0);
    check("rst_data4", 64'(ks4.ks_data_o), 64'd0);
    check("rst_level", 64'(lvl1), 64'd0);
    check("rst_busy", 64'(busy1), 64'd0);
    check("rst_wrap", 64'(wrap1), 64'd0);
    nrst = 1'b1;
    step(1);

    // zero nonce, zero key, first-block latency
    key = 128'd0;
    do_restart(32'd0, 1'b1, 1'b1);
    for (int c = 0; c < 4; c++) expect_block(32'd0, 32'(c), 128'd0);
    wait_valid(n);
    check("t1_latency", 64'(n), 64'd35);
    wait_pops(16, 4, 200, "t1_drain");

    // nonce 12345678, four blocks, words low first
    key = K1;
    do_restart(32'h12345678, 1'b1, 1'b1);
    for (int c = 0; c < 6; c++) expect_block(32'h12345678, 32'(c), K1);
    wait_pops(32, 8, 400, "t2_blocks");

    // backpressure: fill, hold, then drain with concurrent refill
    do_restart(32'h12345678, 1'b1, 1'b0);
    for (int c = 0; c < 6; c++) expect_block(32'h12345678, 32'(c), K1);
    begin
      int c = 0;
      while (!(lvl1 == 2'd2 && busy1 == 1'b0) && c < 200) begin
        @(posedge clk); #1; c++;
      end
    end
    check("t3_level1", 64'(lvl1), 64'd2);
    check("t3_level4", 64'(lvl4), 64'd2);
    check("t3_busy1", 64'(busy1), 64'd0);
    check("t3_busy4", 64'(busy4), 64'd0);
    check("t3_head1", 64'(ks1.ks_data_o), 64'(q1[0]));
    check("t3_head4", 64'(ks4.ks_data_o), 64'(q4[0]));
    step(10);
    check("t3_hold1", 64'(ks1.ks_data_o), 64'(q1[0]));
    check("t3_hold4", 64'(ks4.ks_data_o), 64'(q4[0]));
    ready = 1'b1;
    begin
      int c0;
      c0 = p1;
      repeat (16) @(negedge clk);
      #1;
      check("t3_burst16", 64'(p1 - c0), 64'd16);
    end
    @(posedge clk); #1;
    check("t3_drained", 64'(lvl1), 64'd0);
    wait_pops(32, 8, 300, "t3_refill");

    // counter wrap via backdoor
    key = K2;
    do_restart(32'hCAFEF00D, 1'b0, 1'b1);
    force u_d1.r_ctr = 32'hFFFF_FFFE;
    force u_d4.r_ctr = 32'hFFFF_FFFE;
    @(posedge clk); #1;
    release u_d1.r_ctr;
    release u_d4.r_ctr;
    expect_block(32'hCAFEF00D, 32'hFFFF_FFFE, K2);
    expect_block(32'hCAFEF00D, 32'hFFFF_FFFF, K2);
    expect_block(32'hCAFEF00D, 32'h0000_0000, K2);
    expect_block(32'hCAFEF00D, 32'h0000_0001, K2);
    enable = 1'b1;
    wait_pops(8, 2, 200, "t4_blk0");
    check("t4_wrap1_pre", 64'(wrap1), 64'd0);
    check("t4_wrap4_pre", 64'(wrap4), 64'd0);
    wait_pops(24, 6, 300, "t4_blk2");
    check("t4_wrap1", 64'(wrap1), 64'd1);
    check("t4_wrap4", 64'(wrap4), 64'd1);
    ready = 1'b0;

    // restart mid-ROUND with one block buffered
    wait_level1(2'd1, 100, "t5_level_pre");
    step(10);
    check("t5_busy_pre", 64'(busy1), 64'd1);
    do_restart(32'h0BADBEEF, 1'b1, 1'b1);
    check("t5_level1", 64'(lvl1), 64'd0);
    check("t5_level4", 64'(lvl4), 64'd0);
    check("t5_busy1", 64'(busy1), 64'd0);
    check("t5_wrap1", 64'(wrap1), 64'd0);
    check("t5_wrap4", 64'(wrap4), 64'd0);
    expect_block(32'h0BADBEEF, 32'd0, K2);
    expect_block(32'h0BADBEEF, 32'd1, K2);
    wait_valid(n);
    check("t5_latency", 64'(n), 64'd35);

    // enable dropped and key changed while block 1 is in ROUND
    @(posedge clk); #1;
    step(10);
    enable = 1'b0;
    key = K3;
    wait_pops(16, 4, 200, "t6_inflight");
    step(60);
    check("t6_busy1", 64'(busy1), 64'd0);
    check("t6_busy4", 64'(busy4), 64'd0);
    check("t6_level1", 64'(lvl1), 64'd0);
    check("t6_pops1", 64'(p1), 64'd16);
    expect_block(32'h0BADBEEF, 32'd2, K3);
    enable = 1'b1;
    begin
      int c = 0;
      while (!busy1 && c < 20) begin
        @(posedge clk); #1; c++;
      end
    end
    enable = 1'b0;
    wait_pops(24, 6, 200, "t6_newkey");
    step(20);
    check("t6_q1_empty", 64'(q1.size()), 64'd0);
    check("t6_q4_empty", 64'(q4.size()), 64'd0);

    // asynchronous reset mid-block with data buffered
    ready = 1'b0;
    enable = 1'b1;
    wait_level1(2'd1, 100, "t7_level_pre");
    step(5);
    check("t7_busy_pre", 64'(busy1), 64'd1);
    #2 nrst = 1'b0;
    #1;
    check("t7_level1", 64'(lvl1), 64'd0);
    check("t7_level4", 64'(lvl4), 64'd0);
    check("t7_busy1", 64'(busy1), 64'd0);
    check("t7_valid1", 64'(ks1.ks_valid_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
